// File: rtl/vote.sv
// Ballot-box controller: arms one vote per Ballot press, keeps 15 saturating
// per-candidate tallies plus a saturating total, and drives a 12-bit display word.
module vote (
    input  logic        clk,
    input  logic        Clear,
    input  logic        Power,
    input  logic        Close,
    input  logic        Ballot,
    input  logic        Total,
    input  logic        Result,
    input  logic [3:0]  IN,
    output logic [11:0] out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        CLOSED = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  count [0:15];
    logic [11:0] total;
    logic [3:0]  idx;
    logic        ballot_prev;
    logic        total_prev;
    logic        result_prev;

    logic        ballot_rise;
    logic        total_rise;
    logic        result_rise;
    logic [3:0]  idx_next;
    logic        take_vote;

    assign ballot_rise = Ballot & ~ballot_prev;
    assign total_rise  = Total  & ~total_prev;
    assign result_rise = Result & ~result_prev;
    assign idx_next    = (idx == 4'd15) ? 4'd1 : idx + 4'd1;
    assign take_vote   = (state == ARMED) && (IN != 4'd0);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (Clear) begin
            state       <= IDLE;
            total       <= 12'd0;
            idx         <= 4'd0;
            out         <= 12'd0;
            ballot_prev <= 1'b0;
            total_prev  <= 1'b0;
            result_prev <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                count[i] <= 8'd0;
            end
        end else begin
            // Edge history tracks the panel even while powered down, so a
            // button held across power-up does not fire a spurious edge.
            ballot_prev <= Ballot;
            total_prev  <= Total;
            result_prev <= Result;

            if (!Power) begin
                out <= 12'd0;
            end else if (Close && state != CLOSED) begin
                state <= CLOSED;
            end else begin
                if (state == CLOSED && result_rise) begin
                    idx <= idx_next;
                    out <= {idx_next, count[idx_next]};
                end else if (total_rise) begin
                    out <= total;
                end else if (ballot_rise && state != CLOSED) begin
                    out <= 12'd0;
                end

                // A vote is taken before a same-cycle re-press; either way
                // exactly one vote results per arm.
                if (take_vote) begin
                    count[IN] <= sat_inc8(count[IN]);
                    total     <= sat_inc12(total);
                    state     <= ballot_rise ? ARMED : IDLE;
                end else if (state == IDLE && ballot_rise) begin
                    state <= ARMED;
                end
            end
        end
    end

endmodule

// File: tb/tb_vote.sv
// Directed bench for vote: drives panel sequences and checks the display word
// against hand-computed values.
module tb_vote;

    logic        clk = 1'b0;
    logic        Clear = 1'b1;
    logic        Power = 1'b1;
    logic        Close = 1'b0;
    logic        Ballot = 1'b0;
    logic        Total = 1'b0;
    logic        Result = 1'b0;
    logic [3:0]  IN = 4'd0;
    logic [11:0] out;

    int checks = 0;
    int failures = 0;

    vote dut (
        .clk    (clk),
        .Clear  (Clear),
        .Power  (Power),
        .Close  (Close),
        .Ballot (Ballot),
        .Total  (Total),
        .Result (Result),
        .IN     (IN),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] exp);
        checks++;
        assert (out === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, out, exp);
        end
    endtask

    task automatic do_clear();
        Clear = 1'b1; tick(); Clear = 1'b0; tick();
    endtask

    task automatic do_vote(input logic [3:0] code);
        Ballot = 1'b1; tick(); Ballot = 1'b0;
        IN = code; tick(); IN = 4'd0; tick();
    endtask

    task automatic do_total();
        Total = 1'b1; tick(); Total = 1'b0; tick();
    endtask

    task automatic do_result();
        Result = 1'b1; tick(); Result = 1'b0; tick();
    endtask

    task automatic do_close();
        Close = 1'b1; tick(); Close = 1'b0; tick();
    endtask

    initial begin
        // Reset
        tick();
        chk("reset_out", 12'h000);
        Clear = 1'b0;
        tick();

        // Single vote: first code counts, later codes ignored
        Ballot = 1'b1; tick(); Ballot = 1'b0; tick();
        IN = 4'd1; tick(); tick();
        IN = 4'd2; tick();
        IN = 4'd0; tick();
        do_total();
        chk("single_total", 12'h001);
        do_close();
        do_result();
        chk("single_c1", 12'h101);
        do_result();
        chk("single_c2", 12'h200);

        // Unarmed input ignored
        do_clear();
        IN = 4'd3; tick(); tick(); IN = 4'd0; tick();
        do_total();
        chk("unarmed_total", 12'h000);
        do_close();
        do_result(); do_result(); do_result();
        chk("unarmed_c3", 12'h300);

        // Result before Close leaves out unchanged
        do_clear();
        do_vote(4'd4);
        do_total();
        chk("preclose_total", 12'h001);
        do_result();
        chk("preclose_result", 12'h001);

        // Held Ballot counts once, held IN counts once
        do_clear();
        Ballot = 1'b1; tick(); tick(); tick(); Ballot = 1'b0;
        IN = 4'd6; tick(); tick(); tick(); IN = 4'd0; tick();
        do_total();
        chk("held_total", 12'h001);

        // Tally check
        do_clear();
        do_vote(4'd5); do_vote(4'd5); do_vote(4'd5);
        do_vote(4'd9); do_vote(4'd1); do_vote(4'd1);
        do_total();
        chk("tally_total", 12'h006);
        do_close();
        do_result();
        chk("tally_r1", 12'h102);
        do_result();
        chk("tally_r2", 12'h200);
        do_result(); do_result(); do_result();
        chk("tally_r5", 12'h503);
        do_result(); do_result(); do_result(); do_result();
        chk("tally_r9", 12'h901);
        for (int i = 10; i <= 15; i++) do_result();
        chk("tally_r15", 12'hF00);
        do_result();
        chk("tally_wrap", 12'h102);

        // Closed: ballots ignored
        do_vote(4'd1);
        do_total();
        chk("closed_total", 12'h006);
        do_result();
        chk("closed_r2", 12'h200);

        // Clear reopens voting
        Clear = 1'b1; tick();
        chk("clear_out", 12'h000);
        Clear = 1'b0; tick();
        do_vote(4'd7);
        do_total();
        chk("reopen_total", 12'h001);
        do_close();
        do_result();
        chk("reopen_c1", 12'h100);

        // Power
        do_clear();
        do_vote(4'd2); do_vote(4'd2);
        do_total();
        chk("pwr_total", 12'h002);
        Power = 1'b0; tick();
        chk("pwr_off_out", 12'h000);
        do_vote(4'd2);
        do_total();
        chk("pwr_off_ignored", 12'h000);
        Power = 1'b1; tick();
        chk("pwr_on_out", 12'h000);
        do_total();
        chk("pwr_retained", 12'h002);

        // Saturation
        do_clear();
        for (int i = 0; i < 256; i++) do_vote(4'd3);
        do_total();
        chk("sat_total", 12'h100);
        do_close();
        do_result(); do_result(); do_result();
        chk("sat_c3", 12'h3FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
